// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one byte-serial UART transmitter between N_REQ frame requesters.
// Requesters are granted round-robin; the granted frame (up to MAX_BYTES
// bytes, byte 0 first) is latched and fed byte by byte into the transmitter
// using the tx_send_go / tx_done handshake. A one-cycle done pulse on the
// granted bit marks frame completion.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : a per-byte watchdog aborts a frame when tx_done does not
//               arrive within TIMEOUT cycles; err pulses, no done is issued.
//   Undefined : no watchdog, err is constant 0, WAIT waits indefinitely.
//
// Ports:
//   sys_clk     in   1                    system clock, rising edge
//   rst_n       in   1                    asynchronous active-low reset
//   req         in   N_REQ                level request, held until done
//   req_data    in   N_REQ*MAX_BYTES*8    frame bytes, slice i = requester i
//   req_len     in   N_REQ*LEN_W          frame length in bytes per requester
//   gnt         out  N_REQ                one-hot grant, high for whole frame
//   done        out  N_REQ                one-cycle completion pulse
//   busy        out  1                    frame in progress (state != IDLE)
//   err         out  1                    one-cycle timeout abort pulse
//   tx_data     out  8                    byte to transmitter, held stable
//   tx_send_go  out  1                    one-cycle transmitter start pulse
//   tx_done     in   1                    one-cycle byte-finished pulse
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int MAX_BYTES = 5,
   parameter int LEN_W     = 3,
   parameter int TIMEOUT   = 200000
) (
   input  logic                          sys_clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*MAX_BYTES*8-1:0]  req_data,
   input  logic [N_REQ*LEN_W-1:0]        req_len,
   output logic [N_REQ-1:0]              gnt,
   output logic [N_REQ-1:0]              done,
   output logic                          busy,
   output logic                          err,
   output logic [7:0]                    tx_data,
   output logic                          tx_send_go,
   input  logic                          tx_done
);

   localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int FRAME_W = MAX_BYTES * 8;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

   // Elaboration-time guard on the parameter set.
   if (N_REQ < 2 || N_REQ > 8 || MAX_BYTES < 1 ||
       MAX_BYTES > (2**LEN_W - 1) || TIMEOUT < 1) begin : g_bad_params
      $error("uart_tx_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q;
   logic [IDX_W-1:0]    ptr_q;     // last requester served
   logic [IDX_W-1:0]    idx_q;     // requester owning the current frame
   logic [FRAME_W-1:0]  frame_q;   // remaining bytes, next byte in [7:0]
   logic [LEN_W-1:0]    len_q;     // clamped frame length
   logic [LEN_W-1:0]    cnt_q;     // bytes launched so far

`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0]     to_cnt_q;
`endif

   // -----------------------------------------------------------------------
   // Round-robin selection: first set request bit after ptr_q, with wrap.
   // -----------------------------------------------------------------------
   logic                sel_found;
   logic [IDX_W-1:0]    sel_idx;
   logic [FRAME_W-1:0]  sel_frame;
   logic [LEN_W-1:0]    sel_len_raw;
   logic [LEN_W-1:0]    sel_len;

   always_comb begin
      int cand;
      // NOTE: every variable gets a default before any conditional write so
      // no path leaves it unassigned, which would otherwise infer a latch.
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = (int'(ptr_q) + i) % N_REQ;
         if (!sel_found && req[IDX_W'(cand)]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(cand);
         end
      end
      sel_frame   = req_data[int'(sel_idx)*FRAME_W +: FRAME_W];
      sel_len_raw = req_len[int'(sel_idx)*LEN_W +: LEN_W];
      sel_len     = (sel_len_raw > MAX_LEN) ? MAX_LEN : sel_len_raw;
   end

   // -----------------------------------------------------------------------
   // Control FSM with registered outputs.
   // -----------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= IDX_W'(N_REQ - 1);
         idx_q      <= '0;
         // NOTE: the frame register is small and explicitly reset so no
         // stale bytes from an aborted frame are ever visible after reset.
         frame_q    <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         gnt        <= '0;
         done       <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
         tx_data    <= 8'h00;
         tx_send_go <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         to_cnt_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads
         // the pre-edge value of each register regardless of statement order.
         tx_send_go <= 1'b0;
         done       <= '0;
         err        <= 1'b0;

         case (state_q)
            IDLE: begin
               if (sel_found) begin
                  idx_q   <= sel_idx;
                  frame_q <= sel_frame;
                  len_q   <= sel_len;
                  gnt     <= N_REQ'(1) << sel_idx;
                  busy    <= 1'b1;
                  state_q <= (sel_len == '0) ? DONE : LOAD;
               end
            end

            LOAD: begin
               tx_send_go <= 1'b1;
               tx_data    <= frame_q[7:0];
               cnt_q      <= cnt_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
               to_cnt_q   <= '0;
`endif
               state_q    <= WAIT;
            end

            WAIT: begin
               if (tx_done) begin
                  frame_q <= frame_q >> 8;
                  state_q <= (cnt_q < len_q) ? LOAD : DONE;
               end
`ifdef ARB_TIMEOUT_EN
               // Abort lands exactly TIMEOUT cycles after the send pulse.
               else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                  err     <= 1'b1;
                  gnt     <= '0;
                  busy    <= 1'b0;
                  cnt_q   <= '0;
                  ptr_q   <= idx_q;
                  state_q <= IDLE;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
`endif
            end

            DONE: begin
               done    <= N_REQ'(1) << idx_q;
               gnt     <= '0;
               busy    <= 1'b0;
               cnt_q   <= '0;
               ptr_q   <= idx_q;
               state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. A transmitter model answers each
// tx_send_go with tx_done 10 cycles later. Expected bytes (with the grant
// that must be active) and expected done vectors are queued when stimulus is
// applied and compared by a monitor as the DUT produces them. Single-frame
// cases come from a table; multi-cycle corner cases are hand sequences.
// Build with +define+ARB_TIMEOUT_EN to include the watchdog sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

   localparam int N_REQ     = 4;
   localparam int MAX_BYTES = 5;
   localparam int LEN_W     = 3;
   localparam int FRAME_W   = MAX_BYTES * 8;
`ifdef ARB_TIMEOUT_EN
   localparam int TIMEOUT   = 50;
   localparam int EXP_ERRS  = 1;
`else
   localparam int TIMEOUT   = 200000;
   localparam int EXP_ERRS  = 0;
`endif
   localparam int TX_LAT    = 10;
   // Per byte: LOAD edge, 10-cycle transmitter latency, WAIT->LOAD edge.
   localparam int CYC_PER_BYTE = TX_LAT + 2;

   logic                         sys_clk;
   logic                         rst_n;
   logic [N_REQ-1:0]             req;
   logic [N_REQ*FRAME_W-1:0]     req_data;
   logic [N_REQ*LEN_W-1:0]       req_len;
   logic [N_REQ-1:0]             gnt;
   logic [N_REQ-1:0]             done;
   logic                         busy;
   logic                         err;
   logic [7:0]                   tx_data;
   logic                         tx_send_go;
   logic                         tx_done;

   logic model_done;
   logic stray_done;
   logic suppress_done;
   int   tx_timer;

   assign tx_done = model_done | stray_done;

   uart_tx_arbiter #(
      .N_REQ     (N_REQ),
      .MAX_BYTES (MAX_BYTES),
      .LEN_W     (LEN_W),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .req        (req),
      .req_data   (req_data),
      .req_len    (req_len),
      .gnt        (gnt),
      .done       (done),
      .busy       (busy),
      .err        (err),
      .tx_data    (tx_data),
      .tx_send_go (tx_send_go),
      .tx_done    (tx_done)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // ----------------------------------------------------------------------
   // Scoreboard and counters
   // ----------------------------------------------------------------------
   typedef struct {
      logic [N_REQ-1:0] gnt;
      logic [7:0]       data;
   } byte_exp_t;

   byte_exp_t        byte_q[$];
   logic [N_REQ-1:0] done_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int send_cnt = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int gnt_cyc  = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_event(input string name, input string what);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %s, expected none", name, what);
   endtask

   task automatic push_byte(input int idx, input logic [7:0] d);
      byte_exp_t e;
      e.gnt  = N_REQ'(1) << idx;
      e.data = d;
      byte_q.push_back(e);
   endtask

   // Step to just after the next falling edge (monitor has already run).
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge sys_clk);
         #1;
      end
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         tick();
         k++;
      end
      if (done_cnt < target) fail_event(name, "timeout");
   endtask

   task automatic wait_sends(input int target, input int budget, input string name);
      int k = 0;
      while (send_cnt < target && k < budget) begin
         tick();
         k++;
      end
      if (send_cnt < target) fail_event(name, "timeout");
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   // ----------------------------------------------------------------------
   // Transmitter model: tx_done TX_LAT cycles after each tx_send_go.
   // ----------------------------------------------------------------------
   initial begin
      model_done = 1'b0;
      tx_timer   = 0;
      forever begin
         @(negedge sys_clk);
         if (tx_send_go) begin
            tx_timer   = TX_LAT;
            model_done = 1'b0;
         end else if (tx_timer > 0) begin
            tx_timer--;
            model_done = (tx_timer == 0) && !suppress_done;
         end else begin
            model_done = 1'b0;
         end
      end
   end

   // ----------------------------------------------------------------------
   // Monitor: grant/busy consistency, byte and done scoreboards.
   // ----------------------------------------------------------------------
   initial begin
      forever begin
         @(negedge sys_clk);
         cyc++;
         if (gnt != '0) gnt_cyc++;
         check("gnt_onehot_busy", {busy, $onehot(gnt)}, {(gnt != '0), (gnt != '0)});
         if (tx_send_go) begin
            send_cnt++;
            if (byte_q.size() == 0) fail_event("send_unexpected", "tx_send_go");
            else begin
               byte_exp_t e;
               e = byte_q.pop_front();
               check("send_gnt_data", {gnt, tx_data}, {e.gnt, e.data});
            end
         end
         if (done != '0) begin
            done_cnt++;
            check("done_gnt_low", gnt, '0);
            if (done_q.size() == 0) fail_event("done_unexpected", "done pulse");
            else check("done_vec", done, done_q.pop_front());
         end
         if (err) err_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got simulation timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   // ----------------------------------------------------------------------
   // Stimulus
   // ----------------------------------------------------------------------
   typedef struct {
      int               idx;
      logic [LEN_W-1:0] len;
      logic [FRAME_W-1:0] data;
      int               exp_sends;
      logic [N_REQ-1:0] exp_done;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int s0;
      int d0;
      int c0;
      int k;
      int nb;

      vecs[0] = '{idx: 0, len: 3'd3, data: 40'h00_00_33_22_11, exp_sends: 3, exp_done: 4'b0001};
      vecs[1] = '{idx: 1, len: 3'd0, data: 40'hDE_AD_BE_EF_01, exp_sends: 0, exp_done: 4'b0010};
      vecs[2] = '{idx: 2, len: 3'd7, data: 40'hC5_C4_C3_C2_C1, exp_sends: 5, exp_done: 4'b0100};
      vecs[3] = '{idx: 3, len: 3'd5, data: 40'h5A_4B_3C_2D_1E, exp_sends: 5, exp_done: 4'b1000};
      vecs[4] = '{idx: 0, len: 3'd6, data: 40'h99_88_77_66_55, exp_sends: 5, exp_done: 4'b0001};

      rst_n         = 1'b0;
      req           = '0;
      req_data      = '0;
      req_len       = '0;
      stray_done    = 1'b0;
      suppress_done = 1'b0;
      tick(3);
      check("reset_outputs", {gnt, done, busy, err, tx_data, tx_send_go}, '0);
      rst_n = 1'b1;
      tick(2);

      // ---- table-driven single-frame cases ----
      foreach (vecs[v]) begin
         for (int j = 0; j < N_REQ * MAX_BYTES; j++) req_data[j*8 +: 8] = 8'($urandom);
         for (int j = 0; j < N_REQ; j++) req_len[j*LEN_W +: LEN_W] = LEN_W'($urandom);
         req_data[vecs[v].idx*FRAME_W +: FRAME_W] = vecs[v].data;
         req_len[vecs[v].idx*LEN_W +: LEN_W]      = vecs[v].len;
         nb = (int'(vecs[v].len) > MAX_BYTES) ? MAX_BYTES : int'(vecs[v].len);
         for (int b = 0; b < nb; b++) push_byte(vecs[v].idx, vecs[v].data[b*8 +: 8]);
         done_q.push_back(vecs[v].exp_done);
         s0      = send_cnt;
         gnt_cyc = 0;
         req     = N_REQ'(1) << vecs[v].idx;
         wait_done(done_cnt + 1, 100, "tbl_done_wait");
         req = '0;
         check("tbl_send_count", send_cnt - s0, vecs[v].exp_sends);
         // Grant edge, then CYC_PER_BYTE per byte, then the DONE edge clears it.
         check("tbl_gnt_cycles", gnt_cyc, 1 + CYC_PER_BYTE * vecs[v].exp_sends);
         check("tbl_queue_empty", byte_q.size(), 0);
         tick(2);
      end

      // ---- stray tx_done in IDLE, input changes and req drop mid-frame ----
      s0 = send_cnt;
      for (int i = 0; i < 3; i++) begin
         stray_done = 1'b1;
         tick();
         stray_done = 1'b0;
         tick(2);
      end
      check("stray_idle_state", {busy, gnt, done}, '0);
      check("stray_idle_sends", send_cnt - s0, 0);

      req_data[3*FRAME_W +: FRAME_W] = 40'hD5_D4_D3_D2_D1;
      req_len[3*LEN_W +: LEN_W]      = 3'd5;
      for (int b = 0; b < 5; b++) push_byte(3, 8'hD1 + 8'(b * 1) + 8'(b * 0));
      done_q.push_back(4'b1000);
      req = 4'b1000;
      k = 0;
      while (gnt == '0 && k < 10) begin
         tick();
         k++;
      end
      check("seq_granted", gnt, 4'b1000);
      req_data[3*FRAME_W +: FRAME_W] = 40'h0F_0E_0D_0C_0B;
      req_len[3*LEN_W +: LEN_W]      = 3'd1;
      wait_sends(s0 + 2, 60, "seq_byte2_wait");
      req = '0;
      wait_done(done_cnt + 1, 100, "seq_done_wait");
      check("seq_send_count", send_cnt - s0, 5);
      check("seq_queue_empty", byte_q.size(), 0);
      tick(2);

      // ---- round robin with all requesters active ----
      apply_reset();
      req_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_data[i*FRAME_W +: 8]  = 8'hA0 + 8'(i);
         req_len[i*LEN_W +: LEN_W] = 3'd1;
      end
      for (int i = 0; i < 5; i++) begin
         push_byte(i % N_REQ, 8'hA0 + 8'(i % N_REQ));
         done_q.push_back(N_REQ'(1) << (i % N_REQ));
      end
      s0 = send_cnt;
      req = 4'b1111;
      wait_done(done_cnt + 5, 200, "rr_done_wait");
      req = '0;
      check("rr_send_count", send_cnt - s0, 5);
      check("rr_queue_empty", byte_q.size(), 0);
      tick(3);

`ifdef ARB_TIMEOUT_EN
      // ---- watchdog abort, then next requester served ----
      apply_reset();
      req_data = '0;
      req_data[0*FRAME_W +: 16]  = 16'h62_61;
      req_data[1*FRAME_W +: 8]   = 8'h71;
      req_len[0*LEN_W +: LEN_W]  = 3'd2;
      req_len[1*LEN_W +: LEN_W]  = 3'd1;
      suppress_done = 1'b1;
      push_byte(0, 8'h61);
      s0 = send_cnt;
      d0 = done_cnt;
      c0 = err_cnt;
      req = 4'b0011;
      wait_sends(s0 + 1, 10, "to_send_wait");
      k = cyc;
      while (err_cnt == c0 && cyc - k < 200) tick();
      check("to_err_latency", cyc - k, TIMEOUT);
      check("to_abort_outputs", {gnt, done, busy}, '0);
      req           = 4'b0010;
      suppress_done = 1'b0;
      push_byte(1, 8'h71);
      done_q.push_back(4'b0010);
      wait_done(d0 + 1, 100, "to_next_done_wait");
      req = '0;
      check("to_done_count", done_cnt - d0, 1);
      check("to_queue_empty", byte_q.size(), 0);
      tick(3);
`endif

      // ---- reset during byte 3 ----
      req_data[2*FRAME_W +: FRAME_W] = 40'hE5_E4_E3_E2_E1;
      req_len[2*LEN_W +: LEN_W]      = 3'd5;
      for (int b = 0; b < 5; b++) push_byte(2, 8'hE1 + 8'(b));
      s0 = send_cnt;
      d0 = done_cnt;
      req = 4'b0100;
      wait_sends(s0 + 3, 60, "rst_byte3_wait");
      tick(3);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", {gnt, done, busy, err, tx_data, tx_send_go}, '0);
      byte_q.delete();
      tick(2);
      rst_n = 1'b1;
      req   = '0;
      tick(15);
      check("rst_no_done", done_cnt - d0, 0);
      for (int i = 0; i < N_REQ; i++) begin
         req_data[i*FRAME_W +: 8]  = 8'hF0 + 8'(i);
         req_len[i*LEN_W +: LEN_W] = 3'd1;
      end
      push_byte(0, 8'hF0);
      done_q.push_back(4'b0001);
      req = 4'b1111;
      wait_done(d0 + 1, 50, "rst_first_grant_wait");
      req = '0;
      check("rst_first_grant_q", byte_q.size(), 0);
      tick(3);

      check("err_pulse_count", err_cnt, EXP_ERRS);
      check("done_queue_empty", done_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
